// File: rtl/nibble_accumulator_pkg.sv
// Shared constants for the nibble accumulator: state encoding, datapath widths and the
// saturation value used when NIBBLE_ACC_SATURATE_EN is defined.
package nibble_accumulator_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned ACC_W    = 8;
  localparam int unsigned CNT_W    = 8;

  localparam logic [ACC_W-1:0] SAT_VAL = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_accumulator_four_bit_adder.sv
// 4-bit ripple-carry adder shared by both passes of the nibble accumulator.
module Four_Bit_Adder
  import nibble_accumulator_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] out,
  output logic                cout
);

  logic [NIBBLE_W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign out[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[NIBBLE_W];

endmodule

// File: rtl/nibble_accumulator.sv
// Two-pass 8-bit accumulator built around a single 4-bit adder: low nibble, then high nibble
// with carry. Define NIBBLE_ACC_SATURATE_EN to clamp acc at 8'hFF on overflow instead of wrapping.
module nibble_accumulator
  import nibble_accumulator_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [NIBBLE_W-1:0] in_data,
  output logic                in_ready,
  input  logic                clear,
  output logic [ACC_W-1:0]    acc,
  output logic                done,
  output logic [CNT_W-1:0]    count,
  output logic                overflow
);

  state_t              state;
  logic [NIBBLE_W-1:0] op_reg;
  logic                carry_reg;

  logic [NIBBLE_W-1:0] add_a;
  logic [NIBBLE_W-1:0] add_b;
  logic                add_cin;
  logic [NIBBLE_W-1:0] add_out;
  logic                add_cout;

  // Adder sees zeros while idle so its inputs stay quiet between operands.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    unique case (state)
      LOW: begin
        add_a = acc[NIBBLE_W-1:0];
        add_b = op_reg;
      end
      HIGH: begin
        add_a   = acc[ACC_W-1:NIBBLE_W];
        add_cin = carry_reg;
      end
      default: ;
    endcase
  end

  assign in_ready = (state == IDLE) && !clear;

  Four_Bit_Adder u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .out  (add_out),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
      carry_reg <= 1'b0;
      op_reg    <= '0;
    end else if (clear) begin
      // In-flight operand is dropped; op_reg is left as-is since it is reloaded on accept.
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
      carry_reg <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_reg <= in_data;
            state  <= LOW;
          end
        end
        LOW: begin
          acc[NIBBLE_W-1:0] <= add_out;
          carry_reg         <= add_cout;
          state             <= HIGH;
        end
        HIGH: begin
          acc[ACC_W-1:NIBBLE_W] <= add_out;
          overflow              <= overflow | add_cout;
`ifdef NIBBLE_ACC_SATURATE_EN
          if (add_cout) begin
            acc <= SAT_VAL;
          end
`endif
          count <= count + 8'd1;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_accumulator.sv
// Self-checking bench for nibble_accumulator: directed scenarios plus random traffic, all
// compared every cycle against a transaction-level model of the running sum.
module tb_nibble_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       in_ready;
  logic       clear = 1'b0;
  logic [7:0] acc;
  logic       done;
  logic [7:0] count;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;

`ifdef NIBBLE_ACC_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  nibble_accumulator dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .clear    (clear),
    .acc      (acc),
    .done     (done),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an operand accepted at an edge is added to the sum two edges later.
  int  m_sum = 0;
  int  m_count = 0;
  bit  m_ovf = 0;
  bit  m_done = 0;
  int  m_busy = 0;
  int  m_op = 0;
  int  m_accepts = 0;
  bit  started = 0;

  always @(posedge clk) begin
    int total;
    started = 1'b1;
    if (rst) begin
      m_sum = 0; m_count = 0; m_ovf = 0; m_done = 0; m_busy = 0; m_op = 0;
    end else if (clear) begin
      m_sum = 0; m_count = 0; m_ovf = 0; m_done = 0; m_busy = 0;
    end else begin
      m_done = 0;
      if (m_busy == 2) begin
        m_busy = 1;
      end else if (m_busy == 1) begin
        m_busy = 0;
        total  = m_sum + m_op;
        if (total > 255) begin
          m_ovf = 1;
          m_sum = Sat ? 255 : total % 256;
        end else begin
          m_sum = total;
        end
        m_count = (m_count + 1) % 256;
        m_done  = 1;
      end else if (in_valid) begin
        m_op   = int'(in_data);
        m_busy = 2;
        m_accepts++;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 32'(in_ready), 32'((m_busy == 0) && !clear));
      chk("done", 32'(done), 32'(m_done));
      chk("count", 32'(count), 32'(m_count));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (m_busy == 0) chk("acc", 32'(acc), 32'(m_sum));
    end
  end

  task automatic send(input logic [3:0] op);
    int tries = 0;
    while (!in_ready && tries < 10) begin
      @(posedge clk); #1;
      tries++;
    end
    if (!in_ready) chk("send_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = op;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits for done after an accept; checks latency/ready gap and pins acc and model to a literal.
  task automatic wait_done(input string name, input logic [7:0] exp_acc, input bit chk_gap);
    int gap = 0;
    int n = 0;
    bit found = 0;
    while (!found && n < 8) begin
      @(negedge clk);
      n++;
      if (done) found = 1;
      else if (!in_ready) gap++;
    end
    chk({name, "_done_seen"}, 32'(found), 32'd1);
    if (chk_gap) begin
      chk({name, "_ready_gap"}, 32'(gap), 32'd2);
      chk({name, "_latency"}, 32'(n), 32'd3);
    end
    chk({name, "_acc"}, 32'(acc), 32'(exp_acc));
    chk({name, "_model"}, 32'(m_sum), 32'(exp_acc));
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    int a0;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_acc", 32'(acc), 32'h00);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // Nibble carry
    send(4'd9);  wait_done("nc1", 8'h09, 1'b1);
    send(4'd9);  wait_done("nc2", 8'h12, 1'b1);
    chk("nc_count", 32'(count), 32'd2);

    // Carry chain
    do_clear();
    send(4'd15); wait_done("cc1", 8'h0F, 1'b1);
    send(4'd1);  wait_done("cc2", 8'h10, 1'b1);
    chk("cc_ovf", 32'(overflow), 32'd0);

    // Overflow
    do_clear();
    for (int i = 0; i < 17; i++) begin
      send(4'd15); wait_done("ov_fill", 8'(15 * (i + 1)), 1'b0);
    end
    send(4'd1);
    wait_done("ov", Sat ? 8'hFF : 8'h00, 1'b1);
    chk("ov_flag", 32'(overflow), 32'd1);
    chk("ov_count", 32'(count), 32'd18);

    // Clear during LOW
    do_clear();
    send(4'd15); wait_done("cl_p1", 8'h0F, 1'b0);
    send(4'd15); wait_done("cl_p2", 8'h1E, 1'b0);
    send(4'd2);  wait_done("cl_p3", 8'h20, 1'b0);
    in_valid = 1'b1;
    in_data  = 4'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    clear    = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("cl_acc", 32'(acc), 32'h00);
    chk("cl_count", 32'(count), 32'd0);
    chk("cl_done", 32'(done), 32'd0);
    chk("cl_ready", 32'(in_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("cl_no_done", 32'(done), 32'd0);
    end

    // Back-to-back
    do_clear();
    a0 = m_accepts;
    in_valid = 1'b1;
    in_data  = 4'd1;
    repeat (30) @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_accepts", 32'(m_accepts - a0), 32'd10);
    wait_done("b2b", 8'h0A, 1'b0);
    chk("b2b_count", 32'(count), 32'd10);

    // Count wrap: 257 zero operands
    do_clear();
    in_valid = 1'b1;
    in_data  = 4'd0;
    repeat (771) @(negedge clk);
    in_valid = 1'b0;
    wait_done("wrap", 8'h00, 1'b0);
    chk("wrap_count", 32'(count), 32'd1);

    // Random traffic with occasional clear and reset
    do_clear();
    repeat (3000) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 4'($urandom);
      clear    = ($urandom_range(0, 59) == 0);
      rst      = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    rst      = 1'b0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
